// File: rtl/parallel_bus_master_pkg.sv
// Shared types and defaults for the parallel bus master.
package parallel_bus_master_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SETUP        = 3'd1,
    WAIT_ACK     = 3'd2,
    WAIT_RELEASE = 3'd3,
    NEXT         = 3'd4,
    DONE         = 3'd5
  } state_t;

  localparam int unsigned DEFAULT_SETUP_CYCLES   = 2;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1000;

endpackage

// File: rtl/parallel_bus_master_synchronizer.sv
// Two-flop synchronizer for the slave's asynchronous ack_valid.
module parallel_bus_master_synchronizer (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/parallel_bus_master.sv
// Parallel bus master: one address phase then MSB-first data phases per word.
// Optional per-phase ack timeout under PARALLEL_BUS_MASTER_TIMEOUT_EN.
module parallel_bus_master
  import parallel_bus_master_pkg::*;
#(
  parameter int unsigned WIDTH                 = 8,
  parameter int unsigned TRANSACTIONS_PER_WORD = 2,
  parameter int unsigned SETUP_CYCLES          = DEFAULT_SETUP_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES        = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic                                     rw,
  input  logic [WIDTH-1:0]                         address,
  input  logic [TRANSACTIONS_PER_WORD*WIDTH-1:0]   write_data_word,
  output logic [TRANSACTIONS_PER_WORD*WIDTH-1:0]   read_data_word,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     error,
  output logic [WIDTH-1:0]                         bus_out,
  input  logic [WIDTH-1:0]                         bus_in,
  output logic                                     bus_oe,
  output logic                                     read,
  output logic                                     register_select,
  output logic                                     enable,
  input  logic                                     ack_valid
);

  localparam int unsigned WORD_W = TRANSACTIONS_PER_WORD * WIDTH;
  localparam int unsigned IDX_W  = $clog2(TRANSACTIONS_PER_WORD + 1);
  localparam int unsigned SET_W  = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

  state_t             state_q, state_d;
  logic [SET_W-1:0]   scnt_q, scnt_d;
  logic [IDX_W-1:0]   remaining_q, remaining_d;
  logic               rw_q, rw_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic [WORD_W-1:0]  rdata_d;
  logic [WIDTH-1:0]   bus_out_d;
  logic               read_d, rs_d, enable_d, done_d, busy_d;
  logic               ack_s;

`ifdef PARALLEL_BUS_MASTER_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic            error_d;
`endif

  parallel_bus_master_synchronizer synchronizer (
    .clock    (clock),
    .reset    (reset),
    .async_in (ack_valid),
    .sync_out (ack_s)
  );

  assign bus_oe = ~read;

  // Next-state and next-output logic; remaining_q is the slice index of the current data phase.
  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    remaining_d = remaining_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    rdata_d     = read_data_word;
    bus_out_d   = bus_out;
    read_d      = read;
    rs_d        = register_select;
    enable_d    = enable;
`ifdef PARALLEL_BUS_MASTER_TIMEOUT_EN
    tcnt_d      = tcnt_q;
    error_d     = error;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          rw_d        = rw;
          wdata_d     = write_data_word;
          remaining_d = IDX_W'(TRANSACTIONS_PER_WORD);
          rs_d        = 1'b0;
          read_d      = 1'b0;
          bus_out_d   = address;
          scnt_d      = '0;
          state_d     = SETUP;
`ifdef PARALLEL_BUS_MASTER_TIMEOUT_EN
          error_d     = 1'b0;
`endif
        end
      end
      SETUP: begin
        if (scnt_q == SET_W'(SETUP_CYCLES - 1)) begin
          enable_d = 1'b1;
          state_d  = WAIT_ACK;
`ifdef PARALLEL_BUS_MASTER_TIMEOUT_EN
          tcnt_d   = '0;
`endif
        end else begin
          scnt_d = scnt_q + SET_W'(1);
        end
      end
      WAIT_ACK: begin
        if (ack_s) begin
          enable_d = 1'b0;
          state_d  = WAIT_RELEASE;
          if (register_select && rw_q) begin
            for (int k = 0; k < int'(TRANSACTIONS_PER_WORD); k++) begin
              if (k == int'(remaining_q)) rdata_d[k*WIDTH +: WIDTH] = bus_in;
            end
          end
        end
      end
      WAIT_RELEASE: begin
        if (!ack_s) state_d = NEXT;
      end
      NEXT: begin
        if (remaining_q != '0) begin
          remaining_d = remaining_q - IDX_W'(1);
          rs_d        = 1'b1;
          read_d      = rw_q;
          scnt_d      = '0;
          state_d     = SETUP;
          for (int k = 0; k < int'(TRANSACTIONS_PER_WORD); k++) begin
            if (k == int'(remaining_q) - 1) bus_out_d = wdata_q[k*WIDTH +: WIDTH];
          end
        end else begin
          rs_d    = 1'b0;
          read_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef PARALLEL_BUS_MASTER_TIMEOUT_EN
    // Timeout overrides the handshake and abandons any remaining phases.
    if (state_q == WAIT_ACK || state_q == WAIT_RELEASE) begin
      if (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        enable_d = 1'b0;
        error_d  = 1'b1;
        rs_d     = 1'b0;
        read_d   = 1'b0;
        rdata_d  = read_data_word;
        state_d  = DONE;
      end else begin
        tcnt_d = tcnt_q + TO_W'(1);
      end
    end
`endif

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      scnt_q          <= '0;
      remaining_q     <= '0;
      rw_q            <= 1'b0;
      wdata_q         <= '0;
      read_data_word  <= '0;
      bus_out         <= '0;
      read            <= 1'b0;
      register_select <= 1'b0;
      enable          <= 1'b0;
      done            <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state_q         <= state_d;
      scnt_q          <= scnt_d;
      remaining_q     <= remaining_d;
      rw_q            <= rw_d;
      wdata_q         <= wdata_d;
      read_data_word  <= rdata_d;
      bus_out         <= bus_out_d;
      read            <= read_d;
      register_select <= rs_d;
      enable          <= enable_d;
      done            <= done_d;
      busy            <= busy_d;
    end
  end

`ifdef PARALLEL_BUS_MASTER_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tcnt_q <= '0;
      error  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      error  <= error_d;
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_parallel_bus_master.sv
// Directed bench for parallel_bus_master with a behavioural slave and phase monitor.
module tb_parallel_bus_master;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        rw = 1'b0;
  logic [7:0]  address = 8'h00;
  logic [15:0] write_data_word = 16'h0000;
  logic [15:0] read_data_word;
  logic        busy, done, error;
  logic [7:0]  bus_out;
  logic [7:0]  bus_in = 8'h00;
  logic        bus_oe, read, register_select, enable;
  logic        ack_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  // Slave behaviour knobs
  int        ack_delay = 3;
  int        hold = 0;
  bit        never_ack = 1'b0;
  logic [7:0] rd_data [0:1];
  int        rd_idx = 0;

  // Monitor log
  logic [7:0] log_bus [0:63];
  logic       log_rs  [0:63];
  logic       log_rd  [0:63];
  logic       log_oe  [0:63];
  int n = 0, done_cnt = 0, done_at_n = 0, read_hi = 0, cyc = 0;
  int en_rise_cyc = 0, en_fall_cyc = 0;
  logic en_prev = 1'b0;

  parallel_bus_master #(
    .WIDTH(8), .TRANSACTIONS_PER_WORD(2), .SETUP_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .rw(rw), .address(address),
    .write_data_word(write_data_word), .read_data_word(read_data_word),
    .busy(busy), .done(done), .error(error), .bus_out(bus_out), .bus_in(bus_in),
    .bus_oe(bus_oe), .read(read), .register_select(register_select),
    .enable(enable), .ack_valid(ack_valid)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    cyc <= cyc + 1;
    en_prev <= enable;
    if (enable && !en_prev) begin
      log_bus[n] <= bus_out;
      log_rs[n]  <= register_select;
      log_rd[n]  <= read;
      log_oe[n]  <= bus_oe;
      n <= n + 1;
      en_rise_cyc <= cyc;
    end
    if (!enable && en_prev) en_fall_cyc <= cyc;
    if (done) begin
      done_cnt  <= done_cnt + 1;
      done_at_n <= n;
    end
    if (read) read_hi <= read_hi + 1;
  end

  // Slave: ack after ack_delay cycles, release after enable drops plus hold cycles.
  always begin
    @(negedge clock);
    if (reset && enable && !ack_valid && !never_ack) begin
      repeat (ack_delay) @(negedge clock);
      if (read && register_select) begin
        bus_in = rd_data[rd_idx];
        rd_idx = (rd_idx + 1) % 2;
      end
      ack_valid = 1'b1;
      for (int i = 0; i < 300 && enable; i++) @(negedge clock);
      repeat (hold) @(negedge clock);
      ack_valid = 1'b0;
    end
  end

  task automatic do_start(input logic r, input logic [7:0] a, input logic [15:0] d);
    @(negedge clock);
    start = 1'b1; rw = r; address = a; write_data_word = d;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", enable); end
    checks++; if (read !== 1'b0 || register_select !== 1'b0) begin errors++; $display("FAIL reset_read_rs: got %b%b want 00", read, register_select); end
    checks++; if (bus_out !== 8'h00) begin errors++; $display("FAIL reset_bus_out: got %h want 00", bus_out); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b%b want 000", busy, done, error); end
    checks++; if (read_data_word !== 16'h0000 || bus_oe !== 1'b1) begin errors++; $display("FAIL reset_rdata_oe: got %h/%b want 0000/1", read_data_word, bus_oe); end
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_write;
    int b = n, d0 = done_cnt, r0 = read_hi;
    do_start(1'b0, 8'h4c, 16'h3123);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b want 1", busy); end
    wait_done("write_done", 500);
    repeat (3) @(negedge clock);
    checks++; if (n - b !== 3) begin errors++; $display("FAIL write_phase_count: got %0d want 3", n - b); end
    checks++; if (log_bus[b] !== 8'h4c || log_rs[b] !== 1'b0) begin errors++; $display("FAIL write_addr_phase: got %h rs=%b want 4c rs=0", log_bus[b], log_rs[b]); end
    checks++; if (log_bus[b+1] !== 8'h31 || log_rs[b+1] !== 1'b1) begin errors++; $display("FAIL write_data_hi: got %h rs=%b want 31 rs=1", log_bus[b+1], log_rs[b+1]); end
    checks++; if (log_bus[b+2] !== 8'h23 || log_rs[b+2] !== 1'b1) begin errors++; $display("FAIL write_data_lo: got %h rs=%b want 23 rs=1", log_bus[b+2], log_rs[b+2]); end
    checks++; if (read_hi - r0 !== 0) begin errors++; $display("FAIL write_read_low: read high %0d cycles want 0", read_hi - r0); end
    checks++; if (done_cnt - d0 !== 1 || done_at_n - b !== 3) begin errors++; $display("FAIL write_done_pulse: pulses %0d after %0d phases want 1 after 3", done_cnt - d0, done_at_n - b); end
    checks++; if (error !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL write_end_flags: error=%b busy=%b want 0 0", error, busy); end
  endtask

  task automatic test_read;
    int b = n, d0 = done_cnt;
    rd_data[0] = 8'h2b; rd_data[1] = 8'h34; rd_idx = 0;
    do_start(1'b1, 8'h4d, 16'hffff);
    wait_done("read_done", 500);
    repeat (3) @(negedge clock);
    checks++; if (read_data_word !== 16'h2b34) begin errors++; $display("FAIL read_word: got %h want 2b34", read_data_word); end
    checks++; if (log_bus[b] !== 8'h4d || log_oe[b] !== 1'b1 || log_rd[b] !== 1'b0) begin errors++; $display("FAIL read_addr_phase: got %h oe=%b rd=%b want 4d 1 0", log_bus[b], log_oe[b], log_rd[b]); end
    checks++; if (log_oe[b+1] !== 1'b0 || log_oe[b+2] !== 1'b0 || log_rd[b+1] !== 1'b1) begin errors++; $display("FAIL read_data_oe: got oe=%b%b rd=%b want 00 1", log_oe[b+1], log_oe[b+2], log_rd[b+1]); end
    checks++; if (done_cnt - d0 !== 1 || read !== 1'b0 || bus_oe !== 1'b1) begin errors++; $display("FAIL read_end: pulses=%0d read=%b oe=%b want 1 0 1", done_cnt - d0, read, bus_oe); end
  endtask

  task automatic test_back_to_back;
    int b = n, d0 = done_cnt;
    do_start(1'b0, 8'h10, 16'ha55a);
    repeat (8) @(negedge clock);
    start = 1'b1; rw = 1'b1; address = 8'h77;
    @(negedge clock);
    start = 1'b0;
    wait_done("b2b_done", 500);
    repeat (40) @(negedge clock);
    checks++; if (n - b !== 3 || done_cnt - d0 !== 1) begin errors++; $display("FAIL b2b_count: phases=%0d pulses=%0d want 3 1", n - b, done_cnt - d0); end
    checks++; if (log_bus[b] !== 8'h10 || log_bus[b+1] !== 8'ha5 || log_bus[b+2] !== 8'h5a) begin errors++; $display("FAIL b2b_values: got %h %h %h want 10 a5 5a", log_bus[b], log_bus[b+1], log_bus[b+2]); end
  endtask

  task automatic test_reset_mid;
    int b = n, d0;
    bit ok = 1'b0;
    do_start(1'b0, 8'h20, 16'h1122);
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (n - b >= 3) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || enable !== 1'b1) begin errors++; $display("FAIL mid_phase_reached: ok=%b enable=%b want 1 1", ok, enable); end
    d0 = done_cnt;
    #2 reset = 1'b0;
    #1;
    checks++; if (enable !== 1'b0 || busy !== 1'b0 || register_select !== 1'b0) begin errors++; $display("FAIL mid_async_reset: en=%b busy=%b rs=%b want 0 0 0", enable, busy, register_select); end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL mid_no_done: pulses %0d want 0", done_cnt - d0); end
    b = n; d0 = done_cnt;
    do_start(1'b0, 8'h4e, 16'h2c56);
    wait_done("after_reset_done", 500);
    repeat (3) @(negedge clock);
    checks++; if (n - b !== 3 || log_bus[b] !== 8'h4e || log_bus[b+1] !== 8'h2c || log_bus[b+2] !== 8'h56) begin errors++; $display("FAIL after_reset_write: phases=%0d %h %h %h want 3 4e 2c 56", n - b, log_bus[b], log_bus[b+1], log_bus[b+2]); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL after_reset_pulse: got %0d want 1", done_cnt - d0); end
  endtask

`ifndef PARALLEL_BUS_MASTER_TIMEOUT_EN
  task automatic test_ack_hold;
    int b = n, bad = 0;
    bit ok = 1'b0;
    hold = 50;
    do_start(1'b0, 8'h30, 16'h0102);
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (n - b >= 1 && !enable) begin ok = 1'b1; break; end
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (enable !== 1'b0 || busy !== 1'b1 || n - b !== 1) bad++;
    end
    checks++; if (!ok || bad != 0) begin errors++; $display("FAIL ack_hold_stall: reached=%b bad_cycles=%0d want 1 0", ok, bad); end
    wait_done("ack_hold_done", 800);
    hold = 0;
    repeat (3) @(negedge clock);
    checks++; if (n - b !== 3 || log_bus[b+2] !== 8'h02) begin errors++; $display("FAIL ack_hold_finish: phases=%0d last=%h want 3 02", n - b, log_bus[b+2]); end
  endtask
`else
  task automatic test_timeout;
    int b = n, d0 = done_cnt;
    bit err_at_done = 1'b0;
    bit ok = 1'b0;
    never_ack = 1'b1;
    do_start(1'b0, 8'h55, 16'h6677);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (done) begin ok = 1'b1; err_at_done = error; break; end
    end
    never_ack = 1'b0;
    repeat (20) @(negedge clock);
    checks++; if (!ok || err_at_done !== 1'b1) begin errors++; $display("FAIL timeout_error: done=%b error=%b want 1 1", ok, err_at_done); end
    checks++; if (en_fall_cyc - en_rise_cyc !== 16) begin errors++; $display("FAIL timeout_span: got %0d want 16", en_fall_cyc - en_rise_cyc); end
    checks++; if (n - b !== 1 || done_cnt - d0 !== 1) begin errors++; $display("FAIL timeout_phases: phases=%0d pulses=%0d want 1 1", n - b, done_cnt - d0); end
    do_start(1'b0, 8'h4c, 16'h3123);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", error); end
    wait_done("timeout_recover_done", 500);
  endtask
`endif

  initial begin
    test_reset;
    test_write;
    test_read;
    test_back_to_back;
    test_reset_mid;
`ifndef PARALLEL_BUS_MASTER_TIMEOUT_EN
    test_ack_hold;
`else
    test_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
